trimmed_mean_filter: RTL
========================

# trimmed_mean_filter

Parametrised trimmed-mean filter for streaming unsigned samples. It collects a window of `2^LOG2_AVG + 2` qualified samples, discards one maximum and one minimum, and averages the rest with a shift. Each completed window produces one registered result and a one-cycle `done_o` pulse. It sits directly behind the sensor/ADC sample path, replacing the fixed 8-bit, fixed-window averager, and adds per-sample qualification, a configurable width and window, and held outputs.

## Interface
- `DATA_W`, 8: sample and result width in bits; minimum 2.
- `LOG2_AVG`, 3: log2 of the number of samples averaged after trimming. Window length `WIN = 2^LOG2_AVG + 2`. Range 0..6.
- `clk`  in  1  — system clock; all state updates on the rising edge.
- `rst`  in  1  — reset, asynchronous, active-high.
- `en_i`  in  1  — filter enable; low aborts and clears the current window.
- `valid_i`  in  1  — `data_i` qualifier; a sample is accepted when `en_i && valid_i`.
- `data_i`  in  DATA_W  — unsigned input sample.
- `data_o`  out  DATA_W  — last window result; holds until the next window completes.
- `done_o`  out  1  — one-cycle pulse when `data_o` updates.

## Operation
- Internal widths:
  - `CNT_W = clog2(WIN)`.
  - `SUM_W = DATA_W + clog2(WIN)`.
  - Accumulator `sum` never wraps inside a window.
- State:
  - `cnt`: samples accepted so far, 0..WIN-1.
  - `sum`: running sum.
  - `max_r`: running maximum, idle value 0.
  - `min_r`: running minimum, idle value all-ones.
- On each accepted sample:
  - `nsum = sum + data_i`.
  - `nmax = max(max_r, data_i)`.
  - `nmin = min(min_r, data_i)`.
- Accept with `cnt < WIN-1`: store `nsum`, `nmax`, `nmin`; `cnt` increments.
- Accept with `cnt == WIN-1` (window complete):
  - `data_o <= (nsum - nmax - nmin + RND) >> LOG2_AVG`, truncated to DATA_W. The result always fits, so no saturation is needed.
  - `done_o <= 1`.
  - `sum`, `max_r`, `min_r`, `cnt` return to their idle values.
  - Windows are consecutive and non-overlapping.
- Duplicate extremes: only one instance of the maximum and one of the minimum are removed.
  - If all samples in the window are equal, the result equals that value.
- Cycle with `en_i && !valid_i`: all state holds; `done_o <= 0`.
- Cycle with `!en_i`:
  - `sum`, `max_r`, `min_r`, `cnt` clear to idle values.
  - `done_o <= 0`.
  - `data_o` holds.
  - A partial window never produces a result.
- State machine: implicit two states, encoded by `cnt`.
  - IDLE/FILL: `cnt < WIN-1`.
  - LAST: `cnt == WIN-1`. The next accepted sample emits a result and returns to `cnt = 0`.
- `en_i` deasserting in the same cycle as the would-be last sample: the abort wins; no result.

## Timing
- Reset values: `data_o = 0`, `done_o = 0`, `cnt = 0`, `sum = 0`, `max_r = 0`, `min_r = all-ones`.
- Latency: `done_o` and `data_o` update on the clock edge that accepts the WIN-th sample. They are visible in the following cycle.
- `done_o` is high for exactly one cycle per window.
- Back-to-back windows with `valid_i` held high produce one `done_o` every WIN cycles.
- No backpressure: every qualified sample is always accepted.
- `rst` asserted mid-window: all state returns to reset values immediately; the partial window is lost. The first accepted sample after `rst` falls starts a fresh window.

## Configuration
- `TRIMMED_MEAN_ROUND_EN`:
  - Defined: `RND = 2^(LOG2_AVG-1)`, giving round-half-up. If `LOG2_AVG == 0`, `RND = 0`.
  - Undefined: `RND = 0`, giving truncation toward zero.

## Test plan
All scenarios use `DATA_W=8`, `LOG2_AVG=3`, `WIN=10`.
- Samples 1..10 on consecutive cycles → one `done_o` pulse the cycle after sample 10; `data_o = 5` (truncate) or `6` (round).
- Ten samples of 255 → `data_o = 255` in both modes; ten samples of 0 → `data_o = 0`.
- Samples 1..10 with `valid_i` low on every other cycle → same result; `done_o` one cycle after the 10th valid sample; no pulse during gaps.
- Samples 0..19 continuous → first pulse `data_o = 4`; second pulse 10 cycles later `data_o = 14` (truncate) or `15` (round).
- Five samples of 200, then `en_i` low one cycle, then ten samples of 8 → no pulse for the aborted window; `data_o = 8`. `en_i` dropped on the 10th sample → no pulse; `data_o` unchanged.
- `rst` pulsed after 6 samples → `data_o = 0`, `done_o = 0` immediately; the next ten samples 1..10 → `data_o = 5` (truncate).

Source files
------------

// File: rtl/trimmed_mean_filter.sv
// Trimmed-mean filter: drops one max and one min from a 2^LOG2_AVG+2 window and averages the rest.
// Result on the edge accepting the last sample; no backpressure. TRIMMED_MEAN_ROUND_EN selects round-half-up.
module trimmed_mean_filter #(
  parameter int DATA_W   = 8,
  parameter int LOG2_AVG = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              done_o
);

  localparam int WIN   = (1 << LOG2_AVG) + 2;
  localparam int CNT_W = $clog2(WIN);
  localparam int SUM_W = DATA_W + $clog2(WIN);
`ifdef TRIMMED_MEAN_ROUND_EN
  localparam int RND_I = (1 << LOG2_AVG) >> 1;
`else
  localparam int RND_I = 0;
`endif
  localparam logic [SUM_W-1:0] RND  = SUM_W'(RND_I);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIN - 1);

  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [SUM_W-1:0]  sum, sum_nxt;
  logic [DATA_W-1:0] max_r, max_nxt;
  logic [DATA_W-1:0] min_r, min_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              done_nxt;

  logic [SUM_W-1:0]  nsum;
  logic [DATA_W-1:0] nmax;
  logic [DATA_W-1:0] nmin;
  logic [SUM_W-1:0]  trimmed;

  assign nsum = sum + SUM_W'(data_i);
  assign nmax = (data_i > max_r) ? data_i : max_r;
  assign nmin = (data_i < min_r) ? data_i : min_r;
  // nsum always covers nmax+nmin, so the subtraction cannot underflow
  assign trimmed = nsum - SUM_W'(nmax) - SUM_W'(nmin) + RND;

  always_comb begin
    cnt_nxt  = cnt;
    sum_nxt  = sum;
    max_nxt  = max_r;
    min_nxt  = min_r;
    data_nxt = data_o;
    done_nxt = 1'b0;
    if (!en_i) begin
      cnt_nxt = '0;
      sum_nxt = '0;
      max_nxt = '0;
      min_nxt = '1;
    end else if (valid_i) begin
      if (cnt == LAST) begin
        data_nxt = DATA_W'(trimmed >> LOG2_AVG);
        done_nxt = 1'b1;
        cnt_nxt  = '0;
        sum_nxt  = '0;
        max_nxt  = '0;
        min_nxt  = '1;
      end else begin
        cnt_nxt = cnt + 1'b1;
        sum_nxt = nsum;
        max_nxt = nmax;
        min_nxt = nmin;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      sum    <= '0;
      max_r  <= '0;
      min_r  <= '1;
      data_o <= '0;
      done_o <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      sum    <= sum_nxt;
      max_r  <= max_nxt;
      min_r  <= min_nxt;
      data_o <= data_nxt;
      done_o <= done_nxt;
    end
  end

endmodule
